// File: rtl/det_event_logger_pkg.sv
// Shared constants for the pattern detector / event logger pair.
// Both blocks import this so the defaults and the pattern stay in step.
`timescale 1ns/1ps
package det_event_logger_pkg;

  localparam int unsigned DEF_TS_W  = 16;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  // Serial pattern matched by the upstream detector.
  localparam logic [7:0] DET_PATTERN = 8'b1011_0110;

  // Occupancy width: must be able to represent DEPTH itself.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/det_event_logger_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Synchronous active-low reset; flush_i empties it and wins over push/pop.
`timescale 1ns/1ps
module det_event_logger_sync_fifo
  import det_event_logger_pkg::*;
#(
  parameter  int unsigned W     = DEF_TS_W,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned LVL_W = lvl_w(DEPTH),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  // Empty head reads as zero rather than stale storage.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      pop_ok_s  = pop_i && valid_o;
      push_ok_s = push_i && (!full_o || pop_ok_s);
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: it is only visible through a valid head.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/det_event_logger.sv
// Timestamps detector pulses and queues them for a valid/ready consumer,
// with saturating accepted/dropped counters and a sticky overflow flag.
`timescale 1ns/1ps
module det_event_logger
  import det_event_logger_pkg::*;
#(
  parameter  int unsigned TS_W  = DEF_TS_W,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_i,
  input  logic             clear_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [TS_W-1:0]  evt_ts_o,
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             ovf_o,
  output logic [LVL_W-1:0] level_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;

  // Clear suppresses both the event and the pop in its cycle.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (clear_i) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      drop_s = 1'b0;
    end else begin
      pop_s  = evt_valid_o && evt_ready_i;
      push_s = det_i && (!full_s || pop_s);
      drop_s = det_i && full_s && !pop_s;
    end
  end

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    evt_cnt_d  = evt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (clear_i) begin
      ts_d       = '0;
      evt_cnt_d  = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (push_s && (evt_cnt_q != CNT_MAX)) evt_cnt_d = evt_cnt_q + CNT_W'(1);
      else                                  evt_cnt_d = evt_cnt_q;
      if (drop_s) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        else                       drop_cnt_d = drop_cnt_q;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q       <= '0;
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      evt_cnt_q  <= evt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  det_event_logger_sync_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (clear_i),
    .push_i  (push_s),
    .data_i  (ts_q),
    .pop_i   (pop_s),
    .valid_o (evt_valid_o),
    .data_o  (evt_ts_o),
    .level_o (level_o),
    .full_o  (full_s)
  );

  assign evt_cnt_o  = evt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_det_event_logger.sv
// Scoreboard bench for det_event_logger: default instance against a queue
// model, plus a narrow TS_W=4/CNT_W=4 instance for wrap and saturation.
`timescale 1ns/1ps
module tb_det_event_logger;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, det, rdy, clr;
  logic        valid, ovf;
  logic [15:0] ts, cnt, dcnt;
  logic [3:0]  level;

  logic        s_det, s_rdy, s_clr;
  logic        s_valid, s_ovf;
  logic [3:0]  s_ts, s_cnt, s_dcnt, s_level;

  det_event_logger dut (
    .clk(clk), .reset(reset), .det_i(det), .clear_i(clr),
    .evt_valid_o(valid), .evt_ready_i(rdy), .evt_ts_o(ts),
    .evt_cnt_o(cnt), .drop_cnt_o(dcnt), .ovf_o(ovf), .level_o(level)
  );

  det_event_logger #(.TS_W(4), .DEPTH(8), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .det_i(s_det), .clear_i(s_clr),
    .evt_valid_o(s_valid), .evt_ready_i(s_rdy), .evt_ts_o(s_ts),
    .evt_cnt_o(s_cnt), .drop_cnt_o(s_dcnt), .ovf_o(s_ovf), .level_o(s_level)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  logic [15:0] m_ts;
  int          m_evt, m_drop;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, drive one cycle, advance the model.
  task automatic step(input bit d, input bit r, input bit c);
    bit          pop, push;
    logic [15:0] head;
    @(negedge clk);
    chk("valid", valid, (sb_q.size() != 0));
    chk("head_ts", ts, (sb_q.size() != 0) ? sb_q[0] : 16'h0000);
    chk("level", level, sb_q.size());
    chk("evt_cnt", cnt, m_evt);
    chk("drop_cnt", dcnt, m_drop);
    chk("ovf", ovf, m_ovf);
    det = d; rdy = r; clr = c;
    if (c) begin
      sb_q.delete();
      m_evt = 0; m_drop = 0; m_ovf = 1'b0; m_ts = 16'h0000;
    end else begin
      pop  = (sb_q.size() != 0) && r;
      push = d && ((sb_q.size() < DEPTH) || pop);
      if (pop) begin
        head = sb_q.pop_front();
        chk("drain_ts", ts, head);
      end
      if (push) begin
        sb_q.push_back(m_ts);
        if (m_evt < 65535) m_evt++;
      end else if (d) begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1'b1;
      end
      m_ts = m_ts + 16'd1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int g;
    bit rd, rr, rc;
    reset = 1'b0; det = 1'b1; rdy = 1'b0; clr = 1'b0;
    s_det = 1'b1; s_rdy = 1'b0; s_clr = 1'b0;

    // 1: reset held with det high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_ts", ts, 16'h0000);
    chk("rst_level", level, 4'd0);
    chk("rst_cnt", cnt, 16'h0000);
    chk("rst_drop", dcnt, 16'h0000);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_s_cnt", s_cnt, 4'd0);
    m_ts = 16'h0000; m_evt = 0; m_drop = 0; m_ovf = 1'b0;
    reset = 1'b1; det = 1'b0; s_det = 1'b0;

    // 2: single event at ts=5
    g = 0;
    while (m_ts != 16'd5 && g < 50) begin step(1'b0, 1'b0, 1'b0); g++; end
    step(1'b1, 1'b0, 1'b0);
    chk("t2_valid", valid, 1'b1);
    chk("t2_ts", ts, 16'd5);
    chk("t2_cnt", cnt, 16'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("t2_valid_after_pop", valid, 1'b0);
    chk("t2_level_after_pop", level, 4'd0);

    // 3: fill and overflow from ts=10
    step(1'b0, 1'b0, 1'b1);
    g = 0;
    while (m_ts != 16'd10 && g < 50) begin step(1'b0, 1'b0, 1'b0); g++; end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    chk("t3_level", level, 4'd8);
    chk("t3_drop", dcnt, 16'd2);
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_head", ts, 16'd10);

    // 4: push and pop together while full
    step(1'b1, 1'b1, 1'b0);
    chk("t4_level", level, 4'd8);
    chk("t4_drop", dcnt, 16'd2);
    chk("t4_head", ts, 16'd11);

    // 5: clear beats a coincident event
    repeat (5) step(1'b0, 1'b1, 1'b0);
    chk("t5_level_pre", level, 4'd3);
    step(1'b1, 1'b0, 1'b1);
    chk("t5_valid", valid, 1'b0);
    chk("t5_cnt", cnt, 16'd0);
    chk("t5_drop", dcnt, 16'd0);
    chk("t5_ovf", ovf, 1'b0);
    chk("t5_level", level, 4'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("t5_ts_restart", ts, 16'd0);
    step(1'b0, 1'b1, 1'b0);

    // Mixed traffic with bursty ready and rare clears
    for (int i = 0; i < 300; i++) begin
      rd = ($urandom_range(0, 2) != 0);
      rr = (i % 60 < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 79) == 0);
      step(rd, rr, rc);
    end
    repeat (12) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // 6: narrow instance, timestamp wrap and counter saturation
    @(negedge clk); s_clr = 1'b1;
    @(negedge clk); s_clr = 1'b0;
    repeat (15) @(negedge clk);
    s_det = 1'b1; s_rdy = 1'b1;
    @(negedge clk);
    chk("t6_valid", s_valid, 1'b1);
    chk("t6_ts15", s_ts, 4'd15);
    @(negedge clk);
    chk("t6_ts0", s_ts, 4'd0);
    chk("t6_cnt2", s_cnt, 4'd2);
    repeat (18) @(negedge clk);
    s_det = 1'b0;
    @(negedge clk);
    chk("t6_cnt_sat", s_cnt, 4'd15);
    chk("t6_drop", s_dcnt, 4'd0);
    chk("t6_ovf", s_ovf, 1'b0);
    chk("t6_level", s_level, 4'd0);
    chk("t6_valid_end", s_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
